// File: rtl/vga_cell_timing.sv
// vga_cell_timing: 640x480@60 Hz VGA timing with 8x8 cell indexing.
// A 25 MHz pixel strobe (PIX_EN) is derived from the 50 MHz clock; all
// timing state advances only on strobe edges. Every output is registered
// from next-state counters so HS/VS/ACTIVE/HCS/VCS/GRID describe the same
// pixel with no extra latency.
// Optional feature: define VGA_GRIDLINE_EN to build the GRID cell-boundary
// marker; otherwise GRID is tied low.

module vga_cell_timing #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SW   = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SW   = 2,
  parameter int V_BP   = 33,
  parameter int CELL_W = H_VIS / 8,
  parameter int CELL_H = V_VIS / 8
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  output logic       PIX_EN,
  output logic       HS,
  output logic       VS,
  output logic       ACTIVE,
  output logic [2:0] HCS,
  output logic [2:0] VCS,
  output logic       FRAME_START,
  output logic       GRID
);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC, V_BACK} v_state_t;

  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
  localparam logic [9:0] CW_LAST = 10'(CELL_W - 1);
  localparam logic [9:0] CH_LAST = 10'(CELL_H - 1);

  // Last in-phase count of each horizontal state
  function automatic logic [9:0] h_phase_last(input h_state_t s);
    case (s)
      H_ACT:   h_phase_last = 10'(H_VIS - 1);
      H_FRONT: h_phase_last = 10'(H_FP - 1);
      H_SYNC:  h_phase_last = 10'(H_SW - 1);
      default: h_phase_last = 10'(H_BP - 1);
    endcase
  endfunction

  // Last in-phase count of each vertical state
  function automatic logic [9:0] v_phase_last(input v_state_t s);
    case (s)
      V_ACT:   v_phase_last = 10'(V_VIS - 1);
      V_FRONT: v_phase_last = 10'(V_FP - 1);
      V_SYNC:  v_phase_last = 10'(V_SW - 1);
      default: v_phase_last = 10'(V_BP - 1);
    endcase
  endfunction

  // Horizontal state succession
  function automatic h_state_t h_succ(input h_state_t s);
    case (s)
      H_ACT:   h_succ = H_FRONT;
      H_FRONT: h_succ = H_SYNC;
      H_SYNC:  h_succ = H_BACK;
      default: h_succ = H_ACT;
    endcase
  endfunction

  // Vertical state succession
  function automatic v_state_t v_succ(input v_state_t s);
    case (s)
      V_ACT:   v_succ = V_FRONT;
      V_FRONT: v_succ = V_SYNC;
      V_SYNC:  v_succ = V_BACK;
      default: v_succ = V_ACT;
    endcase
  endfunction

  // started delays the first strobe by one edge after reset release;
  // run marks that pixel (0,0) has been loaded and counting may proceed.
  logic       started;
  logic       run;
  logic       strobe;

  logic [9:0] hcnt, hcnt_nxt;
  logic [9:0] vcnt, vcnt_nxt;
  logic [9:0] hph, hph_nxt;
  logic [9:0] vph, vph_nxt;
  h_state_t   hst, hst_nxt;
  v_state_t   vst, vst_nxt;
  logic [9:0] hsub, hsub_nxt;
  logic [9:0] vsub, vsub_nxt;
  logic [2:0] hcs, hcs_nxt;
  logic [2:0] vcs, vcs_nxt;

  logic       hwrap;
  logic       fwrap;
  logic       act_nxt;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       fs_nxt;

  assign strobe = started & ~PIX_EN;
  assign hwrap  = (hcnt == H_LAST);
  assign fwrap  = hwrap && (vcnt == V_LAST);

  // Pixel strobe generator: low for the first edge after reset, then toggles
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      started <= 1'b0;
      PIX_EN  <= 1'b0;
    end else begin
      started <= 1'b1;
      PIX_EN  <= strobe;
    end
  end

  // Next-state for counters, both FSMs, cell indices and registered outputs
  always_comb begin
    hcnt_nxt = hcnt;
    vcnt_nxt = vcnt;
    hph_nxt  = hph;
    vph_nxt  = vph;
    hst_nxt  = hst;
    vst_nxt  = vst;
    hsub_nxt = hsub;
    vsub_nxt = vsub;
    hcs_nxt  = hcs;
    vcs_nxt  = vcs;

    if (!run) begin
      // First strobe after reset loads pixel (0,0)
      hcnt_nxt = '0;
      vcnt_nxt = '0;
      hph_nxt  = '0;
      vph_nxt  = '0;
      hst_nxt  = H_ACT;
      vst_nxt  = V_ACT;
      hsub_nxt = '0;
      vsub_nxt = '0;
      hcs_nxt  = '0;
      vcs_nxt  = '0;
    end else begin
      hcnt_nxt = hwrap ? 10'd0 : hcnt + 10'd1;

      if (hph == h_phase_last(hst)) begin
        hph_nxt = '0;
        hst_nxt = h_succ(hst);
      end else begin
        hph_nxt = hph + 10'd1;
      end

      if (hwrap) begin
        vcnt_nxt = fwrap ? 10'd0 : vcnt + 10'd1;
        if (vph == v_phase_last(vst)) begin
          vph_nxt = '0;
          vst_nxt = v_succ(vst);
        end else begin
          vph_nxt = vph + 10'd1;
        end
      end

      // Column-of-cell tracking restarts at every line start
      if (hwrap) begin
        hsub_nxt = '0;
        hcs_nxt  = '0;
      end else if (hst_nxt == H_ACT) begin
        if (hsub == CW_LAST) begin
          hsub_nxt = '0;
          hcs_nxt  = hcs + 3'd1;
        end else begin
          hsub_nxt = hsub + 10'd1;
        end
      end

      // Row-of-cell tracking steps once per visible line, restarts per frame
      if (fwrap) begin
        vsub_nxt = '0;
        vcs_nxt  = '0;
      end else if (hwrap && (vst_nxt == V_ACT)) begin
        if (vsub == CH_LAST) begin
          vsub_nxt = '0;
          vcs_nxt  = vcs + 3'd1;
        end else begin
          vsub_nxt = vsub + 10'd1;
        end
      end
    end

    act_nxt = (hst_nxt == H_ACT) && (vst_nxt == V_ACT);
    hs_nxt  = (hst_nxt != H_SYNC);
    vs_nxt  = (vst_nxt != V_SYNC);
    fs_nxt  = strobe && (hcnt_nxt == 10'd0) && (vcnt_nxt == 10'd0);
  end

  // Timing state and output registers, loaded only on strobe edges
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      run         <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      hph         <= '0;
      vph         <= '0;
      hst         <= H_ACT;
      vst         <= V_ACT;
      hsub        <= '0;
      vsub        <= '0;
      hcs         <= '0;
      vcs         <= '0;
      HS          <= 1'b1;
      VS          <= 1'b1;
      ACTIVE      <= 1'b0;
      HCS         <= '0;
      VCS         <= '0;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= fs_nxt;
      if (strobe) begin
        run    <= 1'b1;
        hcnt   <= hcnt_nxt;
        vcnt   <= vcnt_nxt;
        hph    <= hph_nxt;
        vph    <= vph_nxt;
        hst    <= hst_nxt;
        vst    <= vst_nxt;
        hsub   <= hsub_nxt;
        vsub   <= vsub_nxt;
        hcs    <= hcs_nxt;
        vcs    <= vcs_nxt;
        HS     <= hs_nxt;
        VS     <= vs_nxt;
        ACTIVE <= act_nxt;
        HCS    <= act_nxt ? hcs_nxt : 3'd0;
        VCS    <= act_nxt ? vcs_nxt : 3'd0;
      end
    end
  end

`ifdef VGA_GRIDLINE_EN
  // Marks the first column and first line of every cell during active video
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      GRID <= 1'b0;
    end else if (strobe) begin
      GRID <= act_nxt && ((hsub_nxt == 10'd0) || (vsub_nxt == 10'd0));
    end
  end
`else
  assign GRID = 1'b0;
`endif

endmodule

// File: tb/tb_vga_cell_timing.sv
// Testbench for vga_cell_timing: a full-size instance for reset, line-level
// timing and horizontal cell checks, plus a reduced-geometry instance so
// that frame-level behaviour fits in a short run.
`timescale 1ns/1ps

module tb_vga_cell_timing;

  logic clk = 1'b0;
  logic rst_n_f = 1'b0;
  logic rst_n_s = 1'b0;

  logic       pe_f, hs_f, vs_f, act_f, fs_f, g_f;
  logic [2:0] hcs_f, vcs_f;
  logic       pe_s, hs_s, vs_s, act_s, fs_s, g_s;
  logic [2:0] hcs_s, vcs_s;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int nf   = 0;
  int ns   = 0;

  typedef struct {
    int x; int y;
    bit act; bit hs; bit vs;
    int hcs; int vcs;
    bit grid;
  } vec_t;

  vec_t vf[13];
  vec_t vsm[13];

  vga_cell_timing u_full (
    .CLOCK_50(clk), .RESET_N(rst_n_f), .PIX_EN(pe_f), .HS(hs_f), .VS(vs_f),
    .ACTIVE(act_f), .HCS(hcs_f), .VCS(vcs_f), .FRAME_START(fs_f), .GRID(g_f)
  );

  // 80 px x 39 lines: HS low x 68..75, VS low y 34..35, 8x4 cells
  vga_cell_timing #(
    .H_VIS(64), .H_FP(4), .H_SW(8), .H_BP(4),
    .V_VIS(32), .V_FP(2), .V_SW(2), .V_BP(3),
    .CELL_W(8), .CELL_H(4)
  ) u_small (
    .CLOCK_50(clk), .RESET_N(rst_n_s), .PIX_EN(pe_s), .HS(hs_s), .VS(vs_s),
    .ACTIVE(act_s), .HCS(hcs_s), .VCS(vcs_s), .FRAME_START(fs_s), .GRID(g_s)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pk(input logic pe, input logic hs, input logic vs,
                            input logic ac, input logic [2:0] hc,
                            input logic [2:0] vc, input logic fs,
                            input logic g);
    return int'({pe, hs, vs, ac, hc, vc, fs, g});
  endfunction

  function automatic bit grid_exp(input bit g);
`ifdef VGA_GRIDLINE_EN
    return g;
`else
    return 1'b0 & g;
`endif
  endfunction

  task automatic next_strobe(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if ((sel ? pe_s : pe_f) == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic advance(input bit sel, inout int pos, input int target);
    bit ok;
    while (pos < target) begin
      next_strobe(sel, ok);
      if (!ok) begin
        check("strobe_timeout", 0, 1);
        return;
      end
      pos++;
    end
  endtask

  initial begin
    bit ok;
    int t0, cnt_act, cnt_hs, first_hs, hcs_bad, vs_low, act_bad, grid_bad;
    int fs_extra, vcs_bad, x, y;
    bit ea;

    //            x    y  act hs vs hcs vcs grid
    vf[0]  = '{   0,   0, 1, 1, 1, 0, 0, 1};
    vf[1]  = '{  79,   0, 1, 1, 1, 0, 0, 1};
    vf[2]  = '{  80,   0, 1, 1, 1, 1, 0, 1};
    vf[3]  = '{ 639,   0, 1, 1, 1, 7, 0, 1};
    vf[4]  = '{ 640,   0, 0, 1, 1, 0, 0, 0};
    vf[5]  = '{ 655,   0, 0, 1, 1, 0, 0, 0};
    vf[6]  = '{ 656,   0, 0, 0, 1, 0, 0, 0};
    vf[7]  = '{ 751,   0, 0, 0, 1, 0, 0, 0};
    vf[8]  = '{ 752,   0, 0, 1, 1, 0, 0, 0};
    vf[9]  = '{ 799,   0, 0, 1, 1, 0, 0, 0};
    vf[10] = '{   0,   1, 1, 1, 1, 0, 0, 1};
    vf[11] = '{  81,   1, 1, 1, 1, 1, 0, 0};
    vf[12] = '{ 400,   1, 1, 1, 1, 5, 0, 0};

    vsm[0]  = '{  7,  0, 1, 1, 1, 0, 0, 1};
    vsm[1]  = '{  8,  1, 1, 1, 1, 1, 0, 1};
    vsm[2]  = '{ 63,  3, 1, 1, 1, 7, 0, 0};
    vsm[3]  = '{  0,  4, 1, 1, 1, 0, 1, 1};
    vsm[4]  = '{  9,  5, 1, 1, 1, 1, 1, 0};
    vsm[5]  = '{  3,  8, 1, 1, 1, 0, 2, 1};
    vsm[6]  = '{ 63, 31, 1, 1, 1, 7, 7, 0};
    vsm[7]  = '{ 64, 31, 0, 1, 1, 0, 0, 0};
    vsm[8]  = '{ 68, 31, 0, 0, 1, 0, 0, 0};
    vsm[9]  = '{ 10, 33, 0, 1, 1, 0, 0, 0};
    vsm[10] = '{  0, 34, 0, 1, 0, 0, 0, 0};
    vsm[11] = '{ 70, 35, 0, 0, 0, 0, 0, 0};
    vsm[12] = '{  5, 36, 0, 1, 1, 0, 0, 0};

    // Reset held: both instances at reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_full", pk(pe_f, hs_f, vs_f, act_f, hcs_f, vcs_f, fs_f, g_f), 'h600);
    check("reset_small", pk(pe_s, hs_s, vs_s, act_s, hcs_s, vcs_s, fs_s, g_s), 'h600);

    // Release; first strobe lands on the second edge
    @(negedge clk);
    rst_n_f = 1'b1;
    rst_n_s = 1'b1;
    @(posedge clk); #1;
    check("pen_edge1", pe_f, 0);
    check("fs_edge1", fs_f, 0);
    @(posedge clk); #1;
    check("pen_edge2", pe_f, 1);
    check("fs_edge2", fs_f, 1);
    check("act_edge2", act_f, 1);
    check("hcs_vcs_edge2", {hcs_f, vcs_f}, 0);
    @(posedge clk); #1;
    check("fs_one_cycle", fs_f, 0);
    check("pen_edge3", pe_f, 0);
    nf = 0;

    // Full-size vector table over lines 0 and 1
    foreach (vf[i]) begin
      advance(0, nf, vf[i].y * 800 + vf[i].x);
      check($sformatf("f(%0d,%0d) act", vf[i].x, vf[i].y), act_f, vf[i].act);
      check($sformatf("f(%0d,%0d) hs", vf[i].x, vf[i].y), hs_f, vf[i].hs);
      check($sformatf("f(%0d,%0d) vs", vf[i].x, vf[i].y), vs_f, vf[i].vs);
      check($sformatf("f(%0d,%0d) hcs", vf[i].x, vf[i].y), hcs_f, vf[i].hcs);
      check($sformatf("f(%0d,%0d) vcs", vf[i].x, vf[i].y), vcs_f, vf[i].vcs);
      check($sformatf("f(%0d,%0d) grid", vf[i].x, vf[i].y), g_f, grid_exp(vf[i].grid));
    end

    // Line 2 measured pixel by pixel
    advance(0, nf, 1600);
    t0 = cyc; cnt_act = 0; cnt_hs = 0; first_hs = -1; hcs_bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (act_f) cnt_act++;
      if (!hs_f) begin
        cnt_hs++;
        if (first_hs < 0) first_hs = i;
      end
      if (int'(hcs_f) != ((i < 640) ? i / 80 : 0)) hcs_bad++;
      next_strobe(0, ok);
      if (!ok) begin check("line_timeout", 0, 1); break; end
      nf++;
    end
    check("line_active_count", cnt_act, 640);
    check("line_hs_low_count", cnt_hs, 96);
    check("line_hs_first", first_hs, 656);
    check("line_hcs_errors", hcs_bad, 0);
    check("line_period", cyc - t0, 1600);

    // Abort the small instance mid-frame at (70,30) with an async reset
    ns = nf;
    advance(1, ns, 2470);
    check("pre_abort_hs", hs_s, 0);
    check("pre_abort_pen", pe_s, 1);
    #4;
    rst_n_s = 1'b0;
    #1;
    check("abort_async", pk(pe_s, hs_s, vs_s, act_s, hcs_s, vcs_s, fs_s, g_s), 'h600);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n_s = 1'b1;
    @(posedge clk); #1;
    check("restart_pen_edge1", pe_s, 0);
    @(posedge clk); #1;
    check("restart_pen_edge2", pe_s, 1);
    check("restart_fs", fs_s, 1);
    check("restart_hcs_vcs", {hcs_s, vcs_s}, 0);
    ns = 0;

    // Small-geometry vector table over frame 0
    foreach (vsm[i]) begin
      advance(1, ns, vsm[i].y * 80 + vsm[i].x);
      check($sformatf("s(%0d,%0d) act", vsm[i].x, vsm[i].y), act_s, vsm[i].act);
      check($sformatf("s(%0d,%0d) hs", vsm[i].x, vsm[i].y), hs_s, vsm[i].hs);
      check($sformatf("s(%0d,%0d) vs", vsm[i].x, vsm[i].y), vs_s, vsm[i].vs);
      check($sformatf("s(%0d,%0d) hcs", vsm[i].x, vsm[i].y), hcs_s, vsm[i].hcs);
      check($sformatf("s(%0d,%0d) vcs", vsm[i].x, vsm[i].y), vcs_s, vsm[i].vcs);
      check($sformatf("s(%0d,%0d) grid", vsm[i].x, vsm[i].y), g_s, grid_exp(vsm[i].grid));
    end

    // Whole frame 1 of the small instance
    advance(1, ns, 3120);
    check("frame1_fs", fs_s, 1);
    t0 = cyc; vs_low = 0; act_bad = 0; grid_bad = 0; fs_extra = 0;
    hcs_bad = 0; vcs_bad = 0;
    for (int i = 0; i < 3120; i++) begin
      x = i % 80;
      y = i / 80;
      ea = (x < 64) && (y < 32);
      if (!vs_s) vs_low++;
      if (act_s != ea) act_bad++;
      if (int'(hcs_s) != (ea ? x / 8 : 0)) hcs_bad++;
      if (int'(vcs_s) != (ea ? y / 4 : 0)) vcs_bad++;
      if (g_s != grid_exp(ea && ((x % 8 == 0) || (y % 4 == 0)))) grid_bad++;
      if (i > 0 && fs_s) fs_extra++;
      next_strobe(1, ok);
      if (!ok) begin check("frame_timeout", 0, 1); break; end
      ns++;
    end
    check("frame2_fs", fs_s, 1);
    check("frame_period", cyc - t0, 6240);
    check("frame_vs_low", vs_low, 160);
    check("frame_active_errors", act_bad, 0);
    check("frame_hcs_errors", hcs_bad, 0);
    check("frame_vcs_errors", vcs_bad, 0);
    check("frame_grid_errors", grid_bad, 0);
    check("frame_fs_extra", fs_extra, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
